// File: rtl/ws2812b_frame_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ws2812b_frame_sequencer_pkg
// Purpose  : Shared types and constants for the WS2812B frame sequencer:
//            sequencer states, register map, CTRL/STATUS bit positions and
//            default bit timing at 64 MHz. WS2812B_AUTO_REFRESH_EN enables
//            CTRL bit3 in the top level.
// Revision : 1.0 - initial release
// ============================================================================
package ws2812b_frame_sequencer_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SEND  = 2'd1,
        S_DRAIN = 2'd2,
        S_LATCH = 2'd3
    } state_t;

    localparam logic [3:0] C_ADDR_CTRL   = 4'h0;
    localparam logic [3:0] C_ADDR_STATUS = 4'h1;
    localparam logic [3:0] C_ADDR_PTR    = 4'h2;
    localparam logic [3:0] C_ADDR_DATA   = 4'h3;

    localparam int C_CTRL_START   = 0;
    localparam int C_CTRL_PTR_RST = 1;
    localparam int C_CTRL_OVR_CLR = 2;
    localparam int C_CTRL_AUTO    = 3;

    localparam int C_STAT_BUSY = 0;
    localparam int C_STAT_DONE = 1;
    localparam int C_STAT_OVR  = 2;

    localparam int C_DEF_NUM_LEDS = 4;
    localparam int C_DEF_T0H      = 26;
    localparam int C_DEF_T1H      = 51;
    localparam int C_DEF_TBIT     = 80;
    localparam int C_DEF_TRESET   = 5120;

endpackage : ws2812b_frame_sequencer_pkg
`default_nettype wire

// File: rtl/ws2812b_bit_encoder.sv
`default_nettype none
// ============================================================================
// Module   : ws2812b_bit_encoder
// Purpose  : Serialises bytes MSB first into WS2812B bit cells. Each cell is
//            TBIT cycles: high for T0H/T1H, low for the rest. Ready rises in
//            the final cycle of a byte so bytes stream without gaps.
// Revision : 1.0 - initial release
// ============================================================================
module ws2812b_bit_encoder
    import ws2812b_frame_sequencer_pkg::*;
#(
    parameter int T0H  = C_DEF_T0H,
    parameter int T1H  = C_DEF_T1H,
    parameter int TBIT = C_DEF_TBIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_serial,
    output logic       o_idle
);

    localparam int CW = $clog2(TBIT);
    localparam logic [CW-1:0] C_LAST_CYC = CW'(TBIT - 1);
    localparam logic [CW-1:0] C_T0H      = CW'(T0H);
    localparam logic [CW-1:0] C_T1H      = CW'(T1H);

    logic          r_active;
    logic [7:0]    r_shift;
    logic [2:0]    r_bit;
    logic [CW-1:0] r_cyc;
    logic          w_last;
    logic          w_accept;

    assign w_last   = r_active && (r_bit == 3'd7) && (r_cyc == C_LAST_CYC);
    assign o_ready  = !r_active || w_last;
    assign w_accept = i_valid && o_ready;
    assign o_idle   = !r_active;
    assign o_serial = r_active && (r_cyc < (r_shift[7] ? C_T1H : C_T0H));

    // Bit/cycle counters; a new byte reloads directly over the last cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_active <= 1'b0;
            r_shift  <= 8'h00;
            r_bit    <= 3'd0;
            r_cyc    <= '0;
        end else if (w_accept) begin
            r_active <= 1'b1;
            r_shift  <= i_data;
            r_bit    <= 3'd0;
            r_cyc    <= '0;
        end else if (r_active) begin
            if (r_cyc == C_LAST_CYC) begin
                r_cyc <= '0;
                if (r_bit == 3'd7) begin
                    r_active <= 1'b0;
                end else begin
                    r_bit   <= r_bit + 3'd1;
                    r_shift <= {r_shift[6:0], 1'b0};
                end
            end else begin
                r_cyc <= r_cyc + CW'(1);
            end
        end
    end

endmodule : ws2812b_bit_encoder
`default_nettype wire

// File: rtl/ws2812b_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ws2812b_frame_sequencer
// Purpose  : TinyQV byte peripheral holding a GRB frame buffer and streaming
//            it to a WS2812B chain (uo_out[1]), busy on uo_out[2].
//            Optional feature macro: WS2812B_AUTO_REFRESH_EN (CTRL bit3
//            repeats frames continuously).
// Revision : 1.0 - initial release
// ============================================================================
module ws2812b_frame_sequencer
    import ws2812b_frame_sequencer_pkg::*;
#(
    parameter int NUM_LEDS = C_DEF_NUM_LEDS,
    parameter int T0H      = C_DEF_T0H,
    parameter int T1H      = C_DEF_T1H,
    parameter int TBIT     = C_DEF_TBIT,
    parameter int TRESET   = C_DEF_TRESET
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);

    localparam int DEPTH = NUM_LEDS * 3;
    localparam int IW    = $clog2(DEPTH);
    localparam int LW    = $clog2(TRESET);
    localparam logic [IW-1:0] C_LAST_IDX   = IW'(DEPTH - 1);
    localparam logic [LW-1:0] C_LAST_LATCH = LW'(TRESET - 1);

    state_t        r_state, w_state_nxt;
    logic [IW-1:0] r_idx, w_idx_nxt;
    logic [LW-1:0] r_lcnt, w_lcnt_nxt;
    logic [IW-1:0] r_ptr;
    logic [7:0]    r_buf [DEPTH];
    logic          r_busy, r_done, r_ovr, r_line;
    logic          w_valid, w_frame_done, w_auto;
    logic          w_enc_ready, w_enc_idle, w_serial;
    logic          w_wr_ctrl, w_wr_ptr, w_wr_data;
    logic          w_start, w_buf_open, w_blocked_wr;
    logic          w_unused_ok;

    assign w_unused_ok = &{1'b0, ui_in};

    assign w_wr_ctrl    = data_write && (address == C_ADDR_CTRL);
    assign w_wr_ptr     = data_write && (address == C_ADDR_PTR);
    assign w_wr_data    = data_write && (address == C_ADDR_DATA);
    assign w_start      = w_wr_ctrl && data_in[C_CTRL_START] && !r_busy;
    // Buffer writes are only safe when no frame is reading the buffer, unless
    // continuous refresh is on, where software updates land in a later frame
    assign w_buf_open   = !r_busy || w_auto;
    assign w_blocked_wr = (w_wr_ptr || w_wr_data) && !w_buf_open;

`ifdef WS2812B_AUTO_REFRESH_EN
    logic r_auto;
    // Auto-refresh enable follows CTRL bit3 on every CTRL write
    always_ff @(posedge clk) begin
        if (!rst_n)         r_auto <= 1'b0;
        else if (w_wr_ctrl) r_auto <= data_in[C_CTRL_AUTO];
    end
    assign w_auto = r_auto;
`else
    assign w_auto = 1'b0;
`endif

    ws2812b_bit_encoder #(
        .T0H  (T0H),
        .T1H  (T1H),
        .TBIT (TBIT)
    ) u_encoder (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_valid  (w_valid),
        .i_data   (r_buf[r_idx]),
        .o_ready  (w_enc_ready),
        .o_serial (w_serial),
        .o_idle   (w_enc_idle)
    );

    // Sequencer state, byte index and latch counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_lcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_lcnt  <= w_lcnt_nxt;
        end
    end

    // Sequencer next-state: feed bytes, wait for the last bit, then latch
    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_lcnt_nxt   = r_lcnt;
        w_valid      = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_SEND;
                    w_idx_nxt   = '0;
                end
            end
            S_SEND: begin
                w_valid = 1'b1;
                if (w_enc_ready) begin
                    if (r_idx == C_LAST_IDX) w_state_nxt = S_DRAIN;
                    else                     w_idx_nxt   = r_idx + IW'(1);
                end
            end
            S_DRAIN: begin
                if (w_enc_idle) begin
                    w_state_nxt = S_LATCH;
                    w_lcnt_nxt  = '0;
                end
            end
            S_LATCH: begin
                if (r_lcnt == C_LAST_LATCH) begin
                    w_frame_done = 1'b1;
                    if (w_auto) begin
                        w_state_nxt = S_SEND;
                        w_idx_nxt   = '0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_lcnt_nxt = r_lcnt + LW'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Registered outputs and sticky status flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_ovr  <= 1'b0;
            r_line <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != S_IDLE);
            r_line <= w_serial;
            if (w_start)           r_done <= 1'b0;
            else if (w_frame_done) r_done <= 1'b1;
            if (w_wr_ctrl && data_in[C_CTRL_OVR_CLR]) r_ovr <= 1'b0;
            else if (w_blocked_wr)                    r_ovr <= 1'b1;
        end
    end

    // Buffer pointer: direct load (out-of-range clamps to 0), auto-increment, reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_wr_ptr && w_buf_open) begin
            r_ptr <= (data_in >= 8'(DEPTH)) ? '0 : data_in[IW-1:0];
        end else if (w_wr_data && w_buf_open) begin
            r_ptr <= (r_ptr == C_LAST_IDX) ? '0 : r_ptr + IW'(1);
        end else if (w_wr_ctrl && data_in[C_CTRL_PTR_RST] && !r_busy) begin
            r_ptr <= '0;
        end
    end

    // Pixel buffer storage; contents survive reset
    always_ff @(posedge clk) begin
        if (w_wr_data && w_buf_open) r_buf[r_ptr] <= data_in;
    end

    // Combinational register read mux
    always_comb begin
        data_out = 8'h00;
        case (address)
            C_ADDR_STATUS: data_out = {5'b0, r_ovr, r_done, r_busy};
            C_ADDR_PTR:    data_out = {{(8 - IW){1'b0}}, r_ptr};
            C_ADDR_DATA:   data_out = r_buf[r_ptr];
            default:       data_out = 8'h00;
        endcase
    end

    assign uo_out = {5'b0, r_busy, r_line, 1'b0};

endmodule : ws2812b_frame_sequencer
`default_nettype wire

// File: doc/ws2812b_frame_sequencer.md
# ws2812b_frame_sequencer

TinyQV byte peripheral that stores a frame of GRB pixel data and sequences it onto a WS2812B serial LED chain. The CPU fills an internal pixel buffer through an auto-incrementing data port and writes a start command. The sequencer then streams every byte through a bit-timing encoder with no inter-bit gaps, and finishes with the latch/reset low period. It drives one pin of the output PMOD when the peripheral is selected.

## Interface
- NUM_LEDS, 4: LEDs in chain; buffer depth is NUM_LEDS*3 bytes (max 5).
- T0H, 26: high cycles for a 0 bit (0.40 µs at 64 MHz).
- T1H, 51: high cycles for a 1 bit (0.80 µs).
- TBIT, 80: total cycles per bit (1.25 µs); must exceed T1H.
- TRESET, 5120: low latch cycles after last bit (80 µs).

Ports:
- clk  in  1  clock, nominally 64 MHz.
- rst_n  in  1  reset, synchronous, active-low.
- ui_in  in  8  input PMOD; unused.
- uo_out  out  8  [1] = WS2812B data line, [2] = busy; all other bits 0.
- address  in  4  register address.
- data_write  in  1  write strobe, data_in valid.
- data_in  in  8  write data.
- data_out  out  8  read data, combinational from address.

## Operation
- Register map:
  - 0x0 CTRL (W): bit0 start, bit1 reset pointer to 0, bit2 clear overrun. Reads 0.
  - 0x1 STATUS (R): bit0 busy, bit1 done (sticky until next start), bit2 overrun.
  - 0x2 PTR (R/W): buffer byte index. Writes of values ≥ NUM_LEDS*3 are taken modulo-clamped to 0.
  - 0x3 DATA (R/W): reads/writes buffer[PTR]. Each write increments PTR; PTR wraps from NUM_LEDS*3-1 to 0. Reads do not increment.
  - Other addresses read 0.
- Byte order on the wire follows buffer index 0 first, MSB first. Software stores G,R,B per LED.
- Sequencer FSM:
  - IDLE: wait for start.
  - SEND: offer buffer[idx] to the encoder with valid/ready. Advance idx on each accept.
  - DRAIN: after the last accept, wait for encoder idle.
  - LATCH: hold line low for TRESET cycles.
  - IDLE: set done.
- Start while busy: ignored.
- DATA/PTR write while busy: dropped; overrun set. CTRL bit1 while busy: ignored.
- Simultaneous start and clear-overrun in one CTRL write: both take effect.
- Reset (any time, including mid-frame): line low, busy=0, done=0, overrun=0, PTR=0, FSM IDLE on the next edge. Buffer contents are not reset (X in sim until written).

## Timing
- Write to CTRL start at edge k: busy=1 visible after edge k. The data line rises at edge k+2.
- Each bit is exactly TBIT cycles: high T0H or T1H, then low for the remainder.
- Consecutive bits and bytes are back-to-back. The encoder asserts ready in the last cycle of a byte's final bit, so the next byte's first high cycle directly follows.
- LATCH starts the cycle after the last bit's low phase ends. busy falls and done rises exactly TRESET cycles later.
- Frame length from first rise to busy low: NUM_LEDS*24*TBIT + TRESET cycles.
- All outputs are registered, except data_out.

## Configuration
- WS2812B_AUTO_REFRESH_EN defined:
  - CTRL bit3 becomes auto-refresh enable (reset 0).
  - While it is set, LATCH returns to SEND with idx=0 instead of IDLE, so frames repeat indefinitely.
  - done pulses (set) per frame. busy stays 1.
  - Clearing bit3 lets the current frame finish normally.
  - Buffer writes while busy are then permitted (no overrun), taking effect in whichever frame reads them.
- Undefined: CTRL bit3 is ignored. Behaviour is as above.

## Structure
- Shared package: FSM state enum, register address constants, STATUS/CTRL bit positions, default timing constants.
- Sub-module ws2812b_bit_encoder:
  - Byte valid/ready input, serial output, idle flag.
  - Owns the bit counter (0..7) and cycle counter (0..TBIT-1).
- The top level holds the buffer, register file, sequencer FSM and latch counter.

## Test plan
- Buffer write/readback: write 0x11,0x22,0x33 to DATA from PTR=0. PTR reads 3. Setting PTR=1 makes DATA read 0x22. Writing 12 bytes with NUM_LEDS=4 wraps PTR to 0.
- Single frame, NUM_LEDS=1: buffer 0xA5,0x00,0xFF, start.
  - Decode 24 bits from high widths (26/51) and expect 0xA5,0x00,0xFF, each period 80 cycles.
  - busy stays high for 24*80+5120 cycles, then done=1.
- Start latency: start written at edge k. busy=1 at k+1, line high at k+2. A second start mid-frame is ignored and the frame length is unchanged.
- Overrun: a DATA write during SEND leaves the buffer unchanged and sets STATUS=0x05. CTRL bit2 clears overrun to 0x01.
- Reset mid-bit: assert rst_n=0 during a 1-bit high phase. The line is low and STATUS=0 after the next edge. A new start then produces a full correct frame.
- With WS2812B_AUTO_REFRESH_EN: set bit3 and start. Two consecutive frames are separated by exactly TRESET low cycles. Clearing bit3 ends the sequence after the current frame, with busy=0.
